// File: rtl/buf_pkg.sv
// Shared definitions for the bank-parallel activation buffer (write and read sides).
package buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } buf_state_e;

  localparam int BUF_ADDR_W     = 14;
  localparam int BUF_ARRAY_SIZE = 9;
  localparam int BUF_DATA_SIZE  = 16;

endpackage

// File: rtl/buf_addr_gen.sv
// Bank-index and offset counters that sequence writes across the buffer banks.
// With BUF_WR_INTERLEAVE_EN defined the bank counter is the inner counter; otherwise the offset counter is.
module buf_addr_gen
  import buf_pkg::*;
#(
  parameter int ARRAY_SIZE = BUF_ARRAY_SIZE,
  parameter int ADDR_W     = BUF_ADDR_W
) (
  input  logic                  w_clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       words_per_bank,
  output logic [ARRAY_SIZE-1:0] bank_oh,
  output logic [ADDR_W-1:0]     addr,
  output logic                  last
);

  localparam int BANK_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  logic [BANK_W-1:0] bank_r;
  logic [ADDR_W-1:0] off_r;
  logic [ADDR_W:0]   wpb_m1_s;
  logic              bank_last_s;
  logic              off_last_s;

  assign wpb_m1_s    = words_per_bank - (ADDR_W+1)'(1);
  assign bank_last_s = (bank_r == BANK_W'(ARRAY_SIZE - 1));
  assign off_last_s  = ({1'b0, off_r} == wpb_m1_s);

  assign bank_oh = ARRAY_SIZE'(1) << bank_r;
  assign addr    = base_addr + off_r;
  assign last    = bank_last_s & off_last_s;

  // Counter update: inner counter wraps and carries into the outer one.
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_r <= '0;
      off_r  <= '0;
    end else if (clear) begin
      bank_r <= '0;
      off_r  <= '0;
    end else if (advance) begin
`ifdef BUF_WR_INTERLEAVE_EN
      if (bank_last_s) begin
        bank_r <= '0;
        off_r  <= off_r + ADDR_W'(1);
      end else begin
        bank_r <= bank_r + BANK_W'(1);
      end
`else
      if (off_last_s) begin
        off_r  <= '0;
        bank_r <= bank_r + BANK_W'(1);
      end else begin
        off_r  <= off_r + ADDR_W'(1);
      end
`endif
    end
  end

endmodule

// File: rtl/buffer_write_loader.sv
// Write-side loader: turns a valid/ready word stream into per-bank RAM write strobes.
// Optional macro BUF_WR_INTERLEAVE_EN selects bank-interleaved instead of bank-major order.
module buffer_write_loader
  import buf_pkg::*;
#(
  parameter int ARRAY_SIZE = BUF_ARRAY_SIZE,
  parameter int DATA_SIZE  = BUF_DATA_SIZE,
  parameter int ADDR_W     = BUF_ADDR_W
) (
  input  logic                            w_clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic [ADDR_W:0]                 words_per_bank,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_SIZE-1:0]            s_data,
  output logic [ARRAY_SIZE-1:0]           ena,
  output logic [ARRAY_SIZE-1:0]           wea,
  output logic [ADDR_W*ARRAY_SIZE-1:0]    addra,
  output logic [DATA_SIZE*ARRAY_SIZE-1:0] dina,
  output logic                            busy,
  output logic                            done
);

  buf_state_e                      state_r;
  buf_state_e                      state_nxt_s;
  logic [ADDR_W-1:0]               base_r;
  logic [ADDR_W:0]                 wpb_r;
  logic                            start_acc_s;
  logic                            hs_s;
  logic [ARRAY_SIZE-1:0]           bank_oh_s;
  logic [ADDR_W-1:0]               addr_s;
  logic                            last_s;
  logic                            s_ready_r;
  logic                            busy_r;
  logic                            done_r;
  logic [ARRAY_SIZE-1:0]           ena_r;
  logic [ADDR_W*ARRAY_SIZE-1:0]    addra_r;
  logic [DATA_SIZE*ARRAY_SIZE-1:0] dina_r;

  assign start_acc_s = start && (state_r == ST_IDLE);
  assign hs_s        = s_valid && s_ready_r;

  buf_addr_gen #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .ADDR_W     (ADDR_W)
  ) u_addr_gen (
    .w_clk          (w_clk),
    .rst_n          (rst_n),
    .clear          (start_acc_s),
    .advance        (hs_s),
    .base_addr      (base_r),
    .words_per_bank (wpb_r),
    .bank_oh        (bank_oh_s),
    .addr           (addr_s),
    .last           (last_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = (words_per_bank == '0) ? ST_DONE : ST_FILL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (hs_s && last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, latched fill parameters and status outputs (decoded from next state so they align with state_r).
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      base_r    <= '0;
      wpb_r     <= '0;
      s_ready_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      s_ready_r <= (state_nxt_s == ST_FILL);
      busy_r    <= (state_nxt_s != ST_IDLE);
      done_r    <= (state_nxt_s == ST_DONE);
      if (start_acc_s) begin
        base_r <= base_addr;
        wpb_r  <= words_per_bank;
      end
    end
  end

  // Write port registers: strobe for one cycle per handshake, address/data hold between writes.
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_r   <= '0;
      addra_r <= '0;
      dina_r  <= '0;
    end else if (hs_s) begin
      ena_r   <= bank_oh_s;
      addra_r <= {ARRAY_SIZE{addr_s}};
      dina_r  <= {ARRAY_SIZE{s_data}};
    end else begin
      ena_r   <= '0;
    end
  end

  assign s_ready = s_ready_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign ena     = ena_r;
  assign wea     = ena_r;
  assign addra   = addra_r;
  assign dina    = dina_r;

endmodule

// File: tb/tb_buffer_write_loader.sv
// Randomized self-checking bench for buffer_write_loader against a word-index reference model.
module tb_buffer_write_loader;
  localparam int AS = 9;
  localparam int DW = 16;
  localparam int AW = 14;

  logic              w_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [AW:0]       words_per_bank = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DW-1:0]     s_data = '0;
  logic [AS-1:0]     ena, wea;
  logic [AW*AS-1:0]  addra;
  logic [DW*AS-1:0]  dina;
  logic              busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW*AS-1:0] exp_addra = '0;
  logic [DW*AS-1:0] exp_dina  = '0;

  buffer_write_loader dut (
    .w_clk(w_clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .words_per_bank(words_per_bank), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .busy(busy), .done(done)
  );

  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ena"}, 256'(ena), 256'd0);
    chk({tag, "_wea"}, 256'(wea), 256'd0);
    chk({tag, "_addra"}, 256'(addra), 256'd0);
    chk({tag, "_dina"}, 256'(dina), 256'd0);
    chk({tag, "_ready"}, 256'(s_ready), 256'd0);
    chk({tag, "_busy"}, 256'(busy), 256'd0);
    chk({tag, "_done"}, 256'(done), 256'd0);
  endtask

  // pat: 0 continuous with data=k, 1 toggling valid, 2 random valid. abort_at<0 means no abort.
  task automatic do_fill(input int base, input int wpb, input int pat, input int abort_at);
    int total = wpb * AS;
    int k = 0;
    int cyc = 0;
    int bank, off;
    bit exp_wr = 1'b0;
    bit exp_done = 1'b0;
    bit tog = 1'b1;
    logic [AS-1:0] exp_ena = '0;
    logic [AW-1:0] a;
    @(negedge w_clk);
    chk("idle_ready", 256'(s_ready), 256'd0);
    chk("idle_busy", 256'(busy), 256'd0);
    start = 1'b1;
    base_addr = AW'(base);
    words_per_bank = (AW+1)'(wpb);
    @(negedge w_clk);
    start = 1'b0;
    if (wpb == 0) begin
      chk("zero_done", 256'(done), 256'd1);
      chk("zero_ena", 256'(ena), 256'd0);
      chk("zero_busy", 256'(busy), 256'd1);
      chk("zero_ready", 256'(s_ready), 256'd0);
      @(negedge w_clk);
      chk("zero_done_end", 256'(done), 256'd0);
      chk("zero_busy_end", 256'(busy), 256'd0);
      return;
    end
    while ((k < total || exp_wr) && cyc < 3000) begin
      chk("ena", 256'(ena), exp_wr ? 256'(exp_ena) : 256'd0);
      chk("wea", 256'(wea), exp_wr ? 256'(exp_ena) : 256'd0);
      chk("addra", 256'(addra), 256'(exp_addra));
      chk("dina", 256'(dina), 256'(exp_dina));
      chk("done", 256'(done), 256'(exp_done));
      chk("busy", 256'(busy), 256'd1);
      chk("ready", 256'(s_ready), 256'(k < total));
      if (k == abort_at) begin
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        exp_addra = '0;
        exp_dina  = '0;
        @(negedge w_clk);
        chk_all_zero("abort_hold");
        rst_n = 1'b1;
        return;
      end
      // Stray start requests while busy must be ignored.
      start = ($urandom_range(0, 5) == 0);
      base_addr = AW'($urandom);
      words_per_bank = (AW+1)'($urandom_range(0, 7));
      case (pat)
        0: s_valid = 1'b1;
        1: begin s_valid = tog; tog = ~tog; end
        default: s_valid = ($urandom_range(0, 2) != 0);
      endcase
      s_data = (pat == 0) ? DW'(k) : DW'($urandom);
      if (s_valid && (k < total)) begin
`ifdef BUF_WR_INTERLEAVE_EN
        bank = k % AS;
        off  = k / AS;
`else
        bank = k / wpb;
        off  = k % wpb;
`endif
        a = AW'((base + off) % (1 << AW));
        exp_ena = AS'(1) << bank;
        for (int i = 0; i < AS; i++) begin
          exp_addra[i*AW +: AW] = a;
          exp_dina[i*DW +: DW]  = s_data;
        end
        exp_wr = 1'b1;
        exp_done = (k == total - 1);
        k++;
      end else begin
        exp_wr = 1'b0;
        exp_done = 1'b0;
      end
      @(negedge w_clk);
      cyc++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    if (cyc >= 3000) chk("timeout", 256'd1, 256'd0);
    chk("end_busy", 256'(busy), 256'd0);
    chk("end_done", 256'(done), 256'd0);
    chk("end_ena", 256'(ena), 256'd0);
  endtask

  initial begin
    s_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge w_clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge w_clk);
    chk("post_reset_ready", 256'(s_ready), 256'd0);
    chk("post_reset_ena", 256'(ena), 256'd0);
    s_valid = 1'b0;

    do_fill(32'h100, 4, 0, -1);
    do_fill(32'h100, 4, 1, -1);
    do_fill(32'h3FFF, 2, 0, -1);
    do_fill(32'h3FFF, 2, 2, -1);
    do_fill(32'h55, 0, 0, -1);
    do_fill(32'h200, 4, 0, 10);
    do_fill(32'h200, 4, 0, -1);
    for (int t = 0; t < 12; t++) begin
      do_fill(int'($urandom_range(0, 16383)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 2)), -1);
    end
    do_fill(32'h10, 3, 2, 7);
    do_fill(32'h3FFE, 5, 2, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_write_loader.md
# buffer_write_loader

Write-side loader for the bank-parallel activation buffer. It accepts a valid/ready stream of `DATA_SIZE`-bit words and turns it into per-bank write strobes, addresses and data for the `ARRAY_SIZE` buffer memory banks. The read side and bus multiplexer consume what this block writes. It sits between the input DMA/feature-map stream and the buffer RAM array's write port (clka domain).

## Interface
- `ARRAY_SIZE`, 9: number of buffer banks.
- `DATA_SIZE`, 16: word width.
- `ADDR_W`, 14: bank address width. Fixed by the buffer memory depth of 16384.

- `w_clk`  in  1  write clock. This block has one clock.
- `rst_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  one-cycle pulse that begins a fill. Sampled only in IDLE.
- `base_addr`  in  ADDR_W  first bank address. Sampled on `start`.
- `words_per_bank`  in  ADDR_W+1  words per bank, range 0..16384. Sampled on `start`.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  DATA_SIZE  input word.
- `ena`  out  ARRAY_SIZE  per-bank enable. One-hot during a write, otherwise 0.
- `wea`  out  ARRAY_SIZE  per-bank write enable. Always equal to `ena`.
- `addra`  out  ADDR_W*ARRAY_SIZE  per-bank address. All lanes carry the same value.
- `dina`  out  DATA_SIZE*ARRAY_SIZE  write data. All lanes carry the same word.
- `busy`  out  1  high in FILL and DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, FILL, DONE.
  - IDLE → FILL when `start`=1 and `words_per_bank`≠0.
  - IDLE → DONE when `start`=1 and `words_per_bank`=0. No writes occur.
  - FILL → DONE on the handshake of word number total−1, where total = `words_per_bank`·ARRAY_SIZE.
  - DONE → IDLE unconditionally after one cycle.
- `s_ready` = (state==FILL). It is a registered state decode and has no combinational path from `s_valid`.
- A handshake occurs when `s_valid`&`s_ready`=1.
- Default order is bank-major. Word k goes to bank k / `words_per_bank`, at address `base_addr` + k mod `words_per_bank`.
- Address arithmetic is modulo 2^ADDR_W. For example, base 16383 plus offset 1 writes address 0. No error is raised on wrap.
- `start` in FILL or DONE is ignored. Latched parameters do not change mid-fill.
- Reset during a fill aborts it:
  - all outputs go to 0 and the FSM returns to IDLE;
  - words already written stay in RAM;
  - no `done` pulse is produced.
- Reset values: all outputs are 0, including `s_ready`, `busy` and `done`.

## Timing
- Write latency is 1 cycle. A handshake in cycle n drives `ena`/`wea`/`addra`/`dina` in cycle n+1, for exactly one cycle.
- With no handshake in cycle n, `ena`=`wea`=0 in cycle n+1. `addra`/`dina` hold their previous values.
- Back-to-back handshakes give one write per cycle, so sustained throughput is 1 word/clk.
- `done` is high in the same cycle as the final write strobe (n+1). `busy` falls in cycle n+2.
- With `words_per_bank`=0, `done` pulses in the cycle after `start`.
- The earliest a new `start` is accepted is the cycle `busy`=0.

## Configuration
- `BUF_WR_INTERLEAVE_EN` defined: the order is bank-interleaved. Word k goes to bank k mod ARRAY_SIZE, at address `base_addr` + k / ARRAY_SIZE. Total word count and all timing are unchanged.
- `BUF_WR_INTERLEAVE_EN` undefined: bank-major order as described in Operation.

## Structure
- Shared package `buf_pkg` holds:
  - the state enum (IDLE/FILL/DONE);
  - `BUF_ADDR_W`=14;
  - default `ARRAY_SIZE`/`DATA_SIZE` constants, which the read side also uses.
- Sub-module `buf_addr_gen` holds the bank-index counter (0..ARRAY_SIZE−1) and the offset counter (0..`words_per_bank`−1).
  - It has a `clear` and an `advance` input.
  - It outputs a one-hot bank, the address, and a `last` flag.
  - The macro selects which counter is inner (offset counter inner by default, bank counter inner when interleaved).
- The top level holds the FSM and the output registers.

## Test plan
- Reset behaviour: drive `rst_n`=0 with `s_valid`=1. → All outputs are 0 and `s_ready` stays 0 until `start`.
- Bank-major fill: ARRAY_SIZE=9, `words_per_bank`=4, base 0x100, data 0..35 streamed continuously. → 36 writes. Word 5 writes bank 1 (`ena`=9'h002) at 0x101 with data 5. `done` coincides with the write of word 35 to bank 8 at 0x103.
- Interleaved fill (macro defined), same stimulus. → Word 5 writes bank 5 at 0x100. Word 10 writes bank 1 at 0x101. Word 35 writes bank 8 at 0x103.
- Backpressure gaps: `s_valid` toggles 1,0,1,0. → Writes appear only one cycle after each handshake, with `ena`=0 in gap cycles. The address sequence is the same as in the continuous case.
- Edge cases:
  - base 0x3FFF, `words_per_bank`=2 → the second word of each bank writes address 0x0000.
  - `words_per_bank`=0 → `done` pulses in the cycle after `start` and no `ena`.
- Abort: drop `rst_n` after 10 words. → Outputs are 0 immediately and there is no `done`. A new `start` after reset release fills again from word 0.
